vram_port_arbiter: RTL and testbench

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

---
 rtl/vram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority over a CPU read/write port.
// Optional CPU starvation guard compiled in with `define VRAM_ARB_STARVE_GUARD_EN.
module vram_port_arbiter #(
    parameter int DEPTH      = 600,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic              pixel_clk,
    input  logic              arstn,
    input  logic              disp_req,
    output logic              disp_ready,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [31:0]       disp_rdata,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_rvalid,
    input  logic              cpu_rready,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_wdone,
    output logic              cpu_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD} cpu_state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    cpu_state_e  state_q, state_d;
    logic        disp_in_range, cpu_in_range;
    logic        disp_grant, cpu_grant, starve_hit;
    logic        disp_rd_q, disp_oor_q, disp_rvalid_q;
    logic [31:0] disp_rdata_q;
    logic        cpu_oor_q;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_err_q, cpu_err_d;
    logic        cpu_wdone_q, cpu_wdone_d;

    assign disp_in_range = {1'b0, disp_addr} < DEPTH_L;
    assign cpu_in_range  = {1'b0, cpu_addr} < DEPTH_L;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == CNT_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (cpu_grant)
            starve_d = '0;
        else if (cpu_valid && !starve_hit)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge pixel_clk) begin
        if (!arstn) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    // Display always wins; the wait limit has no effect in this build.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    // Grants are suppressed while reset is asserted so nothing reaches the RAM.
    assign disp_ready = arstn && !starve_hit;
    assign disp_grant = disp_req && disp_ready;
    assign cpu_ready  = arstn && cpu_valid && !disp_grant && (state_q == IDLE);
    assign cpu_grant  = cpu_ready;

    assign ram_en    = (disp_grant && disp_in_range) || (cpu_grant && cpu_in_range);
    assign ram_we    = (cpu_grant && cpu_we && cpu_in_range) ? cpu_wstrb : 4'h0;
    assign ram_addr  = disp_grant ? disp_addr : cpu_addr;
    assign ram_wdata = cpu_wdata;

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = 1'b0;
        cpu_wdone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_grant) begin
                    if (cpu_we) begin
                        cpu_wdone_d = 1'b1;
                        cpu_err_d   = !cpu_in_range;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_d     = RD_HOLD;
                cpu_rdata_d = cpu_oor_q ? 32'h0 : ram_rdata;
                cpu_err_d   = cpu_oor_q;
            end
            RD_HOLD: begin
                cpu_err_d = cpu_err_q;
                if (cpu_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            state_q     <= IDLE;
            cpu_rdata_q <= 32'h0;
            cpu_err_q   <= 1'b0;
            cpu_wdone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            cpu_wdone_q <= cpu_wdone_d;
        end
    end

    // Out-of-range reads are answered with zero once the RAM slot comes round.
    always_ff @(posedge pixel_clk) begin
        if (cpu_grant) cpu_oor_q <= !cpu_in_range;
        disp_oor_q <= !disp_in_range;
    end

    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            disp_rd_q     <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= 32'h0;
        end else begin
            disp_rd_q     <= disp_grant;
            disp_rvalid_q <= disp_rd_q;
            if (disp_rd_q)
                disp_rdata_q <= disp_oor_q ? 32'h0 : ram_rdata;
        end
    end

    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign cpu_rvalid  = (state_q == RD_HOLD);
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_err     = cpu_err_q;
    assign cpu_wdone   = cpu_wdone_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised bench for vram_port_arbiter with a transaction-level reference model and a VRAM model.
module tb_vram_port_arbiter;
    localparam int DEPTH      = 600;
    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              pixel_clk = 1'b0;
    logic              arstn, disp_req, disp_ready, disp_rvalid;
    logic [ADDR_W-1:0] disp_addr, cpu_addr, ram_addr;
    logic [31:0]       disp_rdata, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
    logic              cpu_valid, cpu_ready, cpu_we, cpu_rvalid, cpu_rready;
    logic [3:0]        cpu_wstrb, ram_we;
    logic              cpu_wdone, cpu_err, ram_en;

    always #5 pixel_clk = ~pixel_clk;

    vram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .pixel_clk(pixel_clk), .arstn(arstn),
        .disp_req(disp_req), .disp_ready(disp_ready), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rvalid(cpu_rvalid),
        .cpu_rready(cpu_rready), .cpu_rdata(cpu_rdata), .cpu_wdone(cpu_wdone), .cpu_err(cpu_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Power-up VRAM content is a fixed function of the address.
    function automatic logic [31:0] fill(input int a);
        return 32'(a) * 32'h9E3779B1 + 32'h1234;
    endfunction

    // VRAM: one-cycle read latency, byte-masked writes.
    bit [31:0]   vram [0:1023];
    bit          vram_wr [0:1023];
    logic [31:0] ram_rdata_q;
    assign ram_rdata = ram_rdata_q;
    always @(posedge pixel_clk) begin
        if (ram_en) begin
            ram_rdata_q <= vram_wr[ram_addr] ? vram[ram_addr] : fill(int'(ram_addr));
            if (ram_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) vram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                    else           vram[ram_addr][8*b +: 8] <= ram_rdata_x(int'(ram_addr), b);
                vram_wr[ram_addr] <= 1'b1;
            end
        end
    end
    function automatic logic [7:0] ram_rdata_x(input int a, input int b);
        logic [31:0] w;
        w = vram_wr[a] ? vram[a] : fill(a);
        return w[8*b +: 8];
    endfunction

    // Reference model state
    typedef struct { int due; logic [31:0] data; } disp_rsp_t;
    logic [31:0] ref_mem [0:DEPTH-1];
    disp_rsp_t   dq[$];
    int          cyc, n_chk, n_err;
    bit          rd_pend, rd_err, wd_err;
    int          rd_due, wd_due, wait_cnt;
    logic [31:0] rd_data;

    // Observations for directed checks
    bit          obs_acc, obs_disp_ready, ram_en_seen, rd_seen_err, wd_seen_err;
    int          rd_seen_cyc, wd_seen_cyc, rvalid_cnt, drv_cnt;
    logic [31:0] rd_seen_data, last_disp_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input logic rst_n, input logic dreq, input logic [ADDR_W-1:0] daddr,
                        input logic cv, input logic cwe, input logic [ADDR_W-1:0] caddr,
                        input logic [31:0] cwd, input logic [3:0] cws, input logic crr);
        bit e_dready, e_dacc, e_cacc, e_drv, e_crv, e_wd, e_en;
        logic [3:0] e_we;
        arstn = rst_n; disp_req = dreq; disp_addr = daddr;
        cpu_valid = cv; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        cpu_wstrb = cws; cpu_rready = crr;
        e_dready = rst_n && !(GUARD && wait_cnt == STARVE_MAX);
        e_dacc   = dreq && e_dready;
        e_cacc   = rst_n && cv && !e_dacc && !rd_pend;
        e_en     = (e_dacc && 32'(daddr) < DEPTH) || (e_cacc && 32'(caddr) < DEPTH);
        e_we     = (e_cacc && cwe && 32'(caddr) < DEPTH) ? cws : 4'h0;
        e_drv    = dq.size() > 0 && dq[0].due == cyc;
        e_crv    = rd_pend && rd_due <= cyc;
        e_wd     = (wd_due == cyc);
        @(negedge pixel_clk);
        chk("disp_ready", 32'(disp_ready), 32'(e_dready));
        chk("cpu_ready", 32'(cpu_ready), 32'(e_cacc));
        chk("ram_en", 32'(ram_en), 32'(e_en));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (e_en) chk("ram_addr", 32'(ram_addr), 32'(e_dacc ? daddr : caddr));
        if (e_we != 4'h0) chk("ram_wdata", ram_wdata, cwd);
        if (rst_n) begin
            chk("disp_rvalid", 32'(disp_rvalid), 32'(e_drv));
            if (e_drv) chk("disp_rdata", disp_rdata, dq[0].data);
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
            if (e_crv) begin
                chk("cpu_rdata", cpu_rdata, rd_data);
                chk("cpu_err_rd", 32'(cpu_err), 32'(rd_err));
            end
            chk("cpu_wdone", 32'(cpu_wdone), 32'(e_wd));
            if (e_wd) chk("cpu_err_wr", 32'(cpu_err), 32'(wd_err));
        end
        obs_acc = cpu_valid && cpu_ready;
        obs_disp_ready = disp_ready;
        if (ram_en) ram_en_seen = 1'b1;
        if (cpu_rvalid) begin
            rvalid_cnt++; rd_seen_cyc = cyc; rd_seen_data = cpu_rdata; rd_seen_err = cpu_err;
        end
        if (cpu_wdone) begin wd_seen_cyc = cyc; wd_seen_err = cpu_err; end
        if (disp_rvalid) begin drv_cnt++; last_disp_data = disp_rdata; end
        if (!rst_n) begin
            dq.delete(); rd_pend = 1'b0; wd_due = -1; wait_cnt = 0;
        end else begin
            if (e_drv) dq.delete(0);
            if (e_dacc) dq.push_back('{cyc + 2, (32'(daddr) < DEPTH) ? ref_mem[daddr] : 32'h0});
            if (e_crv && crr) rd_pend = 1'b0;
            if (e_cacc) begin
                if (cwe) begin
                    wd_due = cyc + 1;
                    wd_err = !(32'(caddr) < DEPTH);
                    if (!wd_err)
                        for (int b = 0; b < 4; b++)
                            if (cws[b]) ref_mem[caddr][8*b +: 8] = cwd[8*b +: 8];
                end else begin
                    rd_pend = 1'b1; rd_due = cyc + 2;
                    rd_err  = !(32'(caddr) < DEPTH);
                    rd_data = rd_err ? 32'h0 : ref_mem[caddr];
                end
            end
            if (e_cacc) wait_cnt = 0;
            else if (cv && wait_cnt < STARVE_MAX) wait_cnt++;
        end
        cyc++;
        @(posedge pixel_clk); #1;
    endtask

    task automatic idle(input int n, input logic crr);
        repeat (n) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, crr);
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int acc_cyc);
        acc_cyc = -1;
        for (int i = 0; i < 30 && acc_cyc < 0; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, we, a, d, s, 1'b1);
            if (obs_acc) acc_cyc = cyc - 1;
        end
        if (acc_cyc < 0) chk("cpu_op_timeout", 32'h0, 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
        chk({tag, "_disp_rvalid"}, 32'(disp_rvalid), 32'h0);
        chk({tag, "_cpu_wdone"}, 32'(cpu_wdone), 32'h0);
        chk({tag, "_cpu_err"}, 32'(cpu_err), 32'h0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        chk({tag, "_disp_rdata"}, disp_rdata, 32'h0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)     return ADDR_W'($urandom_range(DEPTH, 1023));
        else if (r < 5) return ADDR_W'($urandom_range(0, DEPTH - 1));
        else            return ADDR_W'($urandom_range(0, 7));
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a, first_acc, low_cnt, ready_hi;
        bit cv_hold, pend_req, r_we;
        logic [ADDR_W-1:0] r_addr;
        logic [31:0] r_wd;
        logic [3:0] r_ws;
        n_chk = 0; n_err = 0; cyc = 0; wd_due = -1; rd_pend = 1'b0; wait_cnt = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill(i);
        arstn = 1'b0; disp_req = 1'b0; disp_addr = '0; cpu_valid = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0; cpu_rready = 1'b0;
        @(posedge pixel_clk); #1;

        // Reset with a CPU request pending: no grant, registered outputs cleared
        repeat (3) step(1'b0, 1'b1, 10'd3, 1'b1, 1'b0, 10'd4, 32'h0, 4'h0, 1'b1);
        check_reset_outputs("rst");
        step(1'b1, 1'b1, 10'd3, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
        chk("rst_disp_ready_first", 32'(obs_disp_ready), 32'h1);
        idle(3, 1'b1);

        // Full write then read-back with latency
        wd_seen_cyc = -1;
        cpu_op(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, a);
        idle(1, 1'b1);
        chk("wr5_wdone_lat", 32'(wd_seen_cyc - a), 32'd1);
        chk("wr5_err", 32'(wd_seen_err), 32'h0);
        cpu_op(1'b0, 10'd5, 32'h0, 4'h0, a);
        idle(3, 1'b1);
        chk("rd5_lat", 32'(rd_seen_cyc - a), 32'd2);
        chk("rd5_data", rd_seen_data, 32'hDEADBEEF);
        chk("rd5_err", 32'(rd_seen_err), 32'h0);

        // Byte-lane merge, then a no-op strobe
        cpu_op(1'b1, 10'd7, 32'h11223344, 4'hF, a);
        cpu_op(1'b1, 10'd7, 32'h0000AA00, 4'b0010, a);
        cpu_op(1'b0, 10'd7, 32'h0, 4'h0, a);
        idle(3, 1'b1);
        chk("rd7_merge", rd_seen_data, 32'h1122AA44);
        wd_seen_cyc = -1;
        cpu_op(1'b1, 10'd7, 32'hFFFFFFFF, 4'h0, a);
        idle(1, 1'b1);
        chk("wr7_noop_done", 32'(wd_seen_cyc - a), 32'd1);
        cpu_op(1'b0, 10'd7, 32'h0, 4'h0, a);
        idle(3, 1'b1);
        chk("rd7_noop_keep", rd_seen_data, 32'h1122AA44);

        // Out-of-range accesses never touch the RAM
        ram_en_seen = 1'b0;
        cpu_op(1'b0, 10'd600, 32'h0, 4'h0, a);
        idle(3, 1'b1);
        chk("rd600_data", rd_seen_data, 32'h0);
        chk("rd600_err", 32'(rd_seen_err), 32'h1);
        wd_seen_cyc = -1;
        cpu_op(1'b1, 10'd700, 32'h55555555, 4'hF, a);
        idle(2, 1'b1);
        chk("wr700_done", 32'(wd_seen_cyc - a), 32'd1);
        chk("wr700_err", 32'(wd_seen_err), 32'h1);
        chk("oor_ram_en", 32'(ram_en_seen), 32'h0);

        // Same-address collision: display first, then sees the CPU write
        cpu_op(1'b1, 10'd9, 32'h01010101, 4'hF, a);
        idle(1, 1'b1);
        step(1'b1, 1'b1, 10'd9, 1'b1, 1'b1, 10'd9, 32'hCAFEF00D, 4'hF, 1'b1);
        chk("col_cpu_wait", 32'(obs_acc), 32'h0);
        step(1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 10'd9, 32'hCAFEF00D, 4'hF, 1'b1);
        chk("col_cpu_acc", 32'(obs_acc), 32'h1);
        step(1'b1, 1'b1, 10'd9, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1);
        idle(3, 1'b1);
        chk("col_disp_new", last_disp_data, 32'hCAFEF00D);

        // Display held busy against a waiting CPU for 20 cycles
        first_acc = -1; low_cnt = 0; cv_hold = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), cv_hold, 1'b1, 10'd3,
                 32'(i), 4'hF, 1'b1);
            if (obs_acc && first_acc < 0) begin first_acc = i; cv_hold = 1'b0; end
            if (!obs_disp_ready) low_cnt++;
        end
        chk("starve_first_acc", 32'(first_acc), GUARD ? 32'd9 : 32'hFFFFFFFF);
        chk("starve_ready_low", 32'(low_cnt), GUARD ? 32'd1 : 32'd0);
        idle(2, 1'b1);

        // Read held by back-pressure while display keeps going
        cpu_op(1'b0, 10'd5, 32'h0, 4'h0, a);
        rvalid_cnt = 0; ready_hi = 0; drv_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b1, 1'b0, 10'd6,
                 32'h0, 4'h0, 1'b0);
            if (obs_acc) ready_hi++;
        end
        chk("hold_rvalid_cnt", 32'(rvalid_cnt), 32'd6);
        chk("hold_cpu_ready", 32'(ready_hi), 32'd0);
        chk("hold_rdata", rd_seen_data, 32'hDEADBEEF);
        chk("hold_disp_served", 32'(drv_cnt), 32'd5);
        idle(2, 1'b1);

        // Reset while a read waits on the RAM: response is dropped
        cpu_op(1'b0, 10'd5, 32'h0, 4'h0, a);
        rvalid_cnt = 0;
        repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
        check_reset_outputs("rdwait_rst");
        idle(4, 1'b1);
        chk("rdwait_rst_no_rvalid", 32'(rvalid_cnt), 32'd0);

        // Random traffic
        pend_req = 1'b0; r_we = 1'b0; r_addr = '0; r_wd = 32'h0; r_ws = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend_req && $urandom_range(0, 1) == 1) begin
                pend_req = 1'b1;
                r_we   = 1'($urandom_range(0, 1));
                r_addr = rand_addr();
                r_wd   = $urandom;
                r_ws   = 4'($urandom_range(0, 15));
            end
            step(1'b1, $urandom_range(0, 9) < 4, rand_addr(), pend_req, r_we, r_addr, r_wd,
                 r_ws, $urandom_range(0, 9) < 7);
            if (obs_acc) pend_req = 1'b0;
        end
        idle(4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
